// File: rtl/uart_prog_loader.sv
// uart_prog_loader: assembles UART bytes into words and streams them into instruction memory
module uart_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] END_WORD  = 32'h0000_0FFF
) (
  input  logic        i_Clock,
  input  logic        rst_ni,
  input  logic        i_En,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_we_req,
  input  logic        i_gnt,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_word_count,
  output logic        o_overrun
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_asm;
  logic        r_we_req;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_word_count;
  logic        r_overrun;
  logic [31:0] w_word;
  logic        w_acc;
  assign w_word = {i_Rx_Byte, r_asm[23:0]};
  assign w_acc  = r_we_req & i_gnt;
  assign o_we_req     = r_we_req;
  assign o_addr       = r_addr;
  assign o_wdata      = r_wdata;
  assign o_be         = r_be;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;
  assign o_overrun    = r_overrun;
  // loader FSM: byte assembly, write issue/accept, terminator and enable handling
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_asm        <= 32'd0;
      r_we_req     <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= 16'd0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_we_req     <= 1'b0;
        r_be         <= 4'h0;
        r_word_count <= r_word_count + 16'd1;
      end
      case (r_state)
        IDLE: if (i_En) begin
          r_state      <= COLLECT;
          r_busy       <= 1'b1;
          r_word_count <= 16'd0;
          r_overrun    <= 1'b0;
          r_idx        <= 2'd0;
        end
        COLLECT: begin
          if (!i_En) begin
            if (r_we_req) r_state <= DRAIN;
            else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (i_Rx_DV) begin
            r_asm[8*r_idx +: 8] <= i_Rx_Byte;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (w_word == END_WORD) begin
                if (r_we_req) r_state <= DRAIN;
                else begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else if (r_we_req) r_overrun <= 1'b1;
              else begin
                r_we_req <= 1'b1;
                r_be     <= 4'hF;
                r_wdata  <= w_word;
                r_addr   <= BASE_ADDR + {14'd0, r_word_count, 2'b00};
              end
            end
          end
        end
        DRAIN: if (!r_we_req || i_gnt) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: if (!i_En) begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed checks of the UART program loader
module tb_uart_prog_loader;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        gnt = 1'b0;
  logic        we_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        busy;
  logic        done;
  logic [15:0] word_count;
  logic        overrun;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  uart_prog_loader dut (
    .i_Clock(clk), .rst_ni(rst_ni), .i_En(en), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte),
    .o_we_req(we_req), .i_gnt(gnt), .o_addr(addr), .o_wdata(wdata), .o_be(be),
    .o_busy(busy), .o_done(done), .o_word_count(word_count), .o_overrun(overrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    dv = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_req"}, {31'd0, we_req}, 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_be"}, {28'd0, be}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_cnt"}, {16'd0, word_count}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask
  initial begin
    #23;
    check_zero("rst");
    @(negedge clk);
    rst_ni = 1'b1;
    gnt = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check("busy_on", {31'd0, busy}, 32'd1);
    send_word(32'h1234_5678);
    check("w0_req", {31'd0, we_req}, 32'd1);
    check("w0_addr", addr, 32'h0);
    check("w0_data", wdata, 32'h1234_5678);
    check("w0_be", {28'd0, be}, 32'hF);
    @(negedge clk);
    check("w0_req_low", {31'd0, we_req}, 32'd0);
    check("w0_be_low", {28'd0, be}, 32'h0);
    check("w0_cnt", {16'd0, word_count}, 32'd1);
    send_word(32'h8765_4321);
    check("w1_req", {31'd0, we_req}, 32'd1);
    check("w1_addr", addr, 32'h4);
    check("w1_data", wdata, 32'h8765_4321);
    @(negedge clk);
    check("w1_req_low", {31'd0, we_req}, 32'd0);
    check("w1_cnt", {16'd0, word_count}, 32'd2);
    send_word(32'h0000_0FFF);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_req", {31'd0, we_req}, 32'd0);
    check("end_cnt", {16'd0, word_count}, 32'd2);
    send_word(32'hDEAD_BEEF);
    check("done_ign_req", {31'd0, we_req}, 32'd0);
    check("done_ign_cnt", {16'd0, word_count}, 32'd2);
    check("done_hold", {31'd0, done}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    gnt = 1'b0;
    en = 1'b1;
    @(negedge clk);
    check("re_cnt", {16'd0, word_count}, 32'd0);
    send_word(32'hAABB_CCDD);
    check("st_req", {31'd0, we_req}, 32'd1);
    check("st_addr", addr, 32'h0);
    check("st_data", wdata, 32'hAABB_CCDD);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      check("st_req_hold", {31'd0, we_req}, 32'd1);
      check("st_addr_hold", addr, 32'h0);
      check("st_data_hold", wdata, 32'hAABB_CCDD);
    end
    send_word(32'h4433_2211);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_req", {31'd0, we_req}, 32'd1);
    check("ovr_data", wdata, 32'hAABB_CCDD);
    check("ovr_cnt", {16'd0, word_count}, 32'd0);
    gnt = 1'b1;
    @(negedge clk);
    check("rel_req", {31'd0, we_req}, 32'd0);
    check("rel_cnt", {16'd0, word_count}, 32'd1);
    repeat (3) @(negedge clk);
    check("rel_no_w2", {31'd0, we_req}, 32'd0);
    check("rel_cnt2", {16'd0, word_count}, 32'd1);
    gnt = 1'b0;
    send_word(32'h0403_0201);
    check("dr_req", {31'd0, we_req}, 32'd1);
    check("dr_addr", addr, 32'h4);
    send_word(32'h0000_0FFF);
    check("dr_busy", {31'd0, busy}, 32'd1);
    check("dr_done", {31'd0, done}, 32'd0);
    check("dr_req_hold", {31'd0, we_req}, 32'd1);
    check("dr_ovr_sticky", {31'd0, overrun}, 32'd1);
    gnt = 1'b1;
    @(negedge clk);
    check("dr_fin_done", {31'd0, done}, 32'd1);
    check("dr_fin_busy", {31'd0, busy}, 32'd0);
    check("dr_fin_req", {31'd0, we_req}, 32'd0);
    check("dr_fin_cnt", {16'd0, word_count}, 32'd2);
    en = 1'b0;
    @(negedge clk);
    check("dr_idle", {31'd0, done}, 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("pt_ovr_clr", {31'd0, overrun}, 32'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    en = 1'b0;
    @(negedge clk);
    check("pt_idle_busy", {31'd0, busy}, 32'd0);
    check("pt_idle_req", {31'd0, we_req}, 32'd0);
    en = 1'b1;
    @(negedge clk);
    send_word(32'hF0DE_BC9A);
    check("pt_req", {31'd0, we_req}, 32'd1);
    check("pt_addr", addr, 32'h0);
    check("pt_data", wdata, 32'hF0DE_BC9A);
    @(negedge clk);
    check("pt_cnt", {16'd0, word_count}, 32'd1);
    gnt = 1'b0;
    send_word(32'h4030_2010);
    check("mr_req", {31'd0, we_req}, 32'd1);
    check("mr_addr", addr, 32'h4);
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("mr_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    gnt = 1'b1;
    @(negedge clk);
    send_word(32'h0A0B_0C0D);
    check("mr_post_req", {31'd0, we_req}, 32'd1);
    check("mr_post_addr", addr, 32'h0);
    check("mr_post_data", wdata, 32'h0A0B_0C0D);
    @(negedge clk);
    check("mr_post_cnt", {16'd0, word_count}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
